// File: rtl/ecliptic_converter_arbiter.sv
// Round-robin arbiter that shares one single-issue integer-to-float
// conversion unit among N_REQ requesters.
// It also holds the dynamic rounding-mode register (frm), resolves dynamic
// rounding per request, and tags each issued operation so that the result
// is routed back to the requester that issued it.
module ecliptic_converter_arbiter #(
    parameter int N_REQ        = 4,
    parameter int CONV_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [1:0]           cfg_rm,
    output logic [1:0]           frm,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_src,
    input  logic [2*N_REQ-1:0]   req_rm,
    input  logic [N_REQ-1:0]     req_dyn,
    input  logic [N_REQ-1:0]     req_unsigned,
    output logic [N_REQ-1:0]     rsp_valid,
    output logic [31:0]          rsp_res,
    output logic                 rsp_inexact,
    output logic                 conv_req,
    output logic [31:0]          conv_src,
    output logic [1:0]           conv_rm,
    output logic                 conv_unsigned,
    input  logic                 conv_ack,
    input  logic [31:0]          conv_res,
    input  logic                 conv_inexact,
    output logic                 busy,
    output logic                 err_spurious_ack,
    output logic                 err_missing_ack
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [ID_W-1:0]         ptr_q, ptr_d;
    logic [1:0]              frm_q, frm_d;
    logic [CONV_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [ID_W-1:0]         tag_id_q [CONV_LATENCY];
    logic [ID_W-1:0]         tag_id_d [CONV_LATENCY];
    logic                    err_spur_q, err_spur_d;
    logic                    err_miss_q, err_miss_d;

    logic                    grant_vld;
    logic [ID_W-1:0]         grant_id;
    logic                    due_vld;
    logic [ID_W-1:0]         due_id;
    logic [31:0]             src_arr [N_REQ];
    logic [1:0]              rm_arr  [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign src_arr[i] = req_src[32*i +: 32];
        assign rm_arr[i]  = req_rm[2*i +: 2];
    end

    // The last tag stage is the operation whose result is due this cycle.
    assign due_vld = tag_vld_q[CONV_LATENCY-1] & ~rst;
    assign due_id  = tag_id_q[CONV_LATENCY-1];

    assign frm              = rst ? 2'd0 : frm_q;
    assign busy             = (|tag_vld_q) & ~rst;
    assign err_spurious_ack = err_spur_q & ~rst;
    assign err_missing_ack  = err_miss_q & ~rst;

    // Cyclic search for the first valid requester at or after ptr.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int cand;
            cand = int'(ptr_q) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!rst && !grant_vld && req_valid[cand[ID_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_id  = cand[ID_W-1:0];
            end
        end
    end

    // Issue the granted request; dynamic rounding uses the pre-write frm.
    always_comb begin
        req_ready     = '0;
        conv_req      = 1'b0;
        conv_src      = '0;
        conv_rm       = '0;
        conv_unsigned = 1'b0;
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
            conv_req            = 1'b1;
            conv_src            = src_arr[grant_id];
            conv_unsigned       = req_unsigned[grant_id];
            conv_rm             = req_dyn[grant_id] ? frm_q : rm_arr[grant_id];
        end
    end

    // Route an acknowledged result to the requester that owns the due tag.
    always_comb begin
        rsp_valid   = '0;
        rsp_res     = '0;
        rsp_inexact = 1'b0;
        if (due_vld && conv_ack) begin
            rsp_valid[due_id] = 1'b1;
            rsp_res           = conv_res;
            rsp_inexact       = conv_inexact;
        end
    end

    // Next-state: pointer advance, frm write, tag shift, sticky error flags.
    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) begin
            ptr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
        frm_d = cfg_we ? cfg_rm : frm_q;
        tag_vld_d[0] = grant_vld;
        tag_id_d[0]  = grant_id;
        for (int k = 1; k < CONV_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end
        err_spur_d = err_spur_q | (conv_ack & ~due_vld);
        err_miss_d = err_miss_q | (due_vld & ~conv_ack);
    end

    // Control state; reset drops every in-flight tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            frm_q      <= 2'd0;
            tag_vld_q  <= '0;
            err_spur_q <= 1'b0;
            err_miss_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            frm_q      <= frm_d;
            tag_vld_q  <= tag_vld_d;
            err_spur_q <= err_spur_d;
            err_miss_q <= err_miss_d;
        end
    end

    // Tag ids are qualified by the valid bits, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

endmodule

// File: tb/tb_ecliptic_converter_arbiter.sv
// Directed bench for ecliptic_converter_arbiter: one instance with
// CONV_LATENCY=1 and one with CONV_LATENCY=3, both with N_REQ=4.
module tb_ecliptic_converter_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    // CONV_LATENCY = 1 instance
    logic         cfg_we;
    logic [1:0]   cfg_rm, frm;
    logic [3:0]   req_valid, req_ready, req_dyn, req_unsigned, rsp_valid;
    logic [127:0] req_src;
    logic [7:0]   req_rm;
    logic [31:0]  rsp_res, conv_src, conv_res;
    logic         rsp_inexact, conv_req, conv_unsigned, conv_ack, conv_inexact;
    logic [1:0]   conv_rm;
    logic         busy, err_spur, err_miss;
    // CONV_LATENCY = 3 instance
    logic         cfg_we3;
    logic [1:0]   cfg_rm3, frm3;
    logic [3:0]   valid3, ready3, dyn3, uns3, rsp3;
    logic [127:0] src3;
    logic [7:0]   rm3;
    logic [31:0]  rsp_res3, conv_src3, conv_res3;
    logic         rsp_inx3, conv_req3, conv_uns3, ack3, conv_inx3;
    logic [1:0]   conv_rm3;
    logic         busy3, err_spur3, err_miss3;

    ecliptic_converter_arbiter #(.N_REQ(4), .CONV_LATENCY(1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_rm(cfg_rm), .frm(frm),
        .req_valid(req_valid), .req_ready(req_ready), .req_src(req_src),
        .req_rm(req_rm), .req_dyn(req_dyn), .req_unsigned(req_unsigned),
        .rsp_valid(rsp_valid), .rsp_res(rsp_res), .rsp_inexact(rsp_inexact),
        .conv_req(conv_req), .conv_src(conv_src), .conv_rm(conv_rm),
        .conv_unsigned(conv_unsigned), .conv_ack(conv_ack), .conv_res(conv_res),
        .conv_inexact(conv_inexact), .busy(busy),
        .err_spurious_ack(err_spur), .err_missing_ack(err_miss)
    );

    ecliptic_converter_arbiter #(.N_REQ(4), .CONV_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we3), .cfg_rm(cfg_rm3), .frm(frm3),
        .req_valid(valid3), .req_ready(ready3), .req_src(src3),
        .req_rm(rm3), .req_dyn(dyn3), .req_unsigned(uns3),
        .rsp_valid(rsp3), .rsp_res(rsp_res3), .rsp_inexact(rsp_inx3),
        .conv_req(conv_req3), .conv_src(conv_src3), .conv_rm(conv_rm3),
        .conv_unsigned(conv_uns3), .conv_ack(ack3), .conv_res(conv_res3),
        .conv_inexact(conv_inx3), .busy(busy3),
        .err_spurious_ack(err_spur3), .err_missing_ack(err_miss3)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] src_tab [4] = '{32'h0000_0011, 32'h0000_0022, 32'h8000_0033, 32'h0000_0044};

    // Expected outstanding op of the latency-1 instance (what the unit returns).
    logic        pend;
    logic [3:0]  pend_oh;
    logic [31:0] pend_res;
    logic        pend_inx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int oh2id(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    // Stand-in conversion result: any distinct per-operand value exposes misrouting.
    function automatic logic [31:0] unit_res(input logic [31:0] s);
        return s ^ 32'h5A5A_0000;
    endfunction

    // One cycle on the latency-1 instance: acks last cycle's issue, checks grant and response.
    task automatic issue_step(input logic [3:0] valid, input logic [3:0] exp_ready, input string tag);
        int id;
        @(negedge clk);
        req_valid    = valid;
        conv_ack     = pend;
        conv_res     = pend ? pend_res : 32'h0;
        conv_inexact = pend & pend_inx;
        #1;
        chk({tag, ".ready"},     32'(req_ready),   32'(exp_ready));
        chk({tag, ".conv_req"},  32'(conv_req),    32'(exp_ready != 4'b0));
        chk({tag, ".rsp_valid"}, 32'(rsp_valid),   pend ? 32'(pend_oh) : 32'h0);
        chk({tag, ".rsp_res"},   rsp_res,          pend ? pend_res : 32'h0);
        chk({tag, ".rsp_inx"},   32'(rsp_inexact), 32'(pend & pend_inx));
        chk({tag, ".busy"},      32'(busy),        32'(pend));
        id = oh2id(exp_ready);
        if (exp_ready != 4'b0) chk({tag, ".conv_src"}, conv_src, src_tab[id]);
        pend     = (exp_ready != 4'b0);
        pend_oh  = exp_ready;
        pend_res = unit_res(src_tab[id]);
        pend_inx = id[0];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_we = 1'b0; cfg_rm = 2'd0;
        req_valid = 4'hF;
        req_src = {src_tab[3], src_tab[2], src_tab[1], src_tab[0]};
        req_rm = 8'h0; req_dyn = 4'h0; req_unsigned = 4'h0;
        conv_ack = 1'b0; conv_res = 32'h0; conv_inexact = 1'b0;
        cfg_we3 = 1'b0; cfg_rm3 = 2'd0; valid3 = 4'h0;
        src3 = {src_tab[3], src_tab[2], src_tab[1], src_tab[0]};
        rm3 = 8'h0; dyn3 = 4'h0; uns3 = 4'h0;
        ack3 = 1'b0; conv_res3 = 32'h0; conv_inx3 = 1'b0;
        pend = 1'b0; pend_oh = 4'h0; pend_res = 32'h0; pend_inx = 1'b0;

        // Reset state, with requests pending that must not be granted.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.ready",    32'(req_ready), 32'h0);
        chk("rst.conv_req", 32'(conv_req),  32'h0);
        chk("rst.frm",      32'(frm),       32'h0);
        chk("rst.busy",     32'(busy),      32'h0);
        chk("rst.err_spur", 32'(err_spur),  32'h0);
        chk("rst.err_miss", 32'(err_miss),  32'h0);
        chk("rst.rsp",      32'(rsp_valid), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'h0;

        // All four valid continuously: grants 0,1,2,3,0,1,2,3.
        for (int c = 0; c < 8; c++) issue_step(4'hF, 4'(1 << (c % 4)), "rr");
        issue_step(4'h0, 4'h0, "rr_flush");

        // Requester 2 alone converts -1 (signed) to -1.0f.
        @(negedge clk);
        req_valid = 4'b0100;
        req_src[95:64] = 32'hFFFF_FFFF;
        conv_ack = 1'b0; conv_res = 32'h0; conv_inexact = 1'b0;
        #1;
        chk("neg1.ready",    32'(req_ready),     32'b0100);
        chk("neg1.conv_req", 32'(conv_req),      32'h1);
        chk("neg1.src",      conv_src,           32'hFFFF_FFFF);
        chk("neg1.rm",       32'(conv_rm),       32'h0);
        chk("neg1.uns",      32'(conv_unsigned), 32'h0);
        @(negedge clk);
        req_valid = 4'b0000;
        conv_ack = 1'b1; conv_res = 32'hBF80_0000;
        #1;
        chk("neg1.rsp_valid", 32'(rsp_valid),   32'b0100);
        chk("neg1.rsp_res",   rsp_res,          32'hBF80_0000);
        chk("neg1.rsp_inx",   32'(rsp_inexact), 32'h0);
        req_src[95:64] = src_tab[2];
        pend = 1'b0;

        // Dynamic rounding: issue in the frm-write cycle sees the old frm.
        @(negedge clk);
        req_valid = 4'b0001; req_dyn = 4'b0001; req_rm = 8'b00_00_00_01;
        req_unsigned = 4'b0001;
        cfg_we = 1'b1; cfg_rm = 2'd3;
        conv_ack = 1'b0; conv_res = 32'h0; conv_inexact = 1'b0;
        #1;
        chk("dyn0.ready", 32'(req_ready),     32'b0001);
        chk("dyn0.rm",    32'(conv_rm),       32'h0);
        chk("dyn0.frm",   32'(frm),           32'h0);
        chk("dyn0.uns",   32'(conv_unsigned), 32'h1);
        @(negedge clk);
        cfg_we = 1'b0;
        conv_ack = 1'b1; conv_res = 32'h3F80_0000; conv_inexact = 1'b1;
        #1;
        chk("dyn1.frm",       32'(frm),         32'h3);
        chk("dyn1.rm",        32'(conv_rm),     32'h3);
        chk("dyn1.ready",     32'(req_ready),   32'b0001);
        chk("dyn1.rsp_valid", 32'(rsp_valid),   32'b0001);
        chk("dyn1.rsp_inx",   32'(rsp_inexact), 32'h1);
        @(negedge clk);
        req_dyn = 4'b0000;
        conv_res = 32'h4000_0000; conv_inexact = 1'b0;
        #1;
        chk("stat.rm",        32'(conv_rm),   32'h1);
        chk("stat.rsp_valid", 32'(rsp_valid), 32'b0001);
        chk("stat.rsp_res",   rsp_res,        32'h4000_0000);
        pend = 1'b1; pend_oh = 4'b0001; pend_res = 32'h4040_0000; pend_inx = 1'b0;
        req_unsigned = 4'h0; req_rm = 8'h0;
        issue_step(4'h0, 4'h0, "dyn_flush");

        // Pointer behaviour with requesters 1 and 3 (ptr is 1 here).
        issue_step(4'b0010, 4'b0010, "p_1");
        issue_step(4'b1010, 4'b1000, "p_3a");
        issue_step(4'b1010, 4'b0010, "p_1b");
        issue_step(4'b1010, 4'b1000, "p_3b");
        issue_step(4'b1011, 4'b0001, "p_0");
        issue_step(4'h0,    4'h0,    "p_flush");

        // Missing ack, then spurious ack, then reset clears both.
        issue_step(4'b0100, 4'b0100, "miss_iss");
        @(negedge clk);
        req_valid = 4'h0; conv_ack = 1'b0; conv_res = 32'h0;
        #1;
        chk("miss.rsp",  32'(rsp_valid), 32'h0);
        chk("miss.busy", 32'(busy),      32'h1);
        pend = 1'b0;
        @(negedge clk);
        #1;
        chk("miss.err_miss", 32'(err_miss), 32'h1);
        chk("miss.err_spur", 32'(err_spur), 32'h0);
        chk("miss.busy0",    32'(busy),     32'h0);
        @(negedge clk);
        conv_ack = 1'b1; conv_res = 32'hDEAD_BEEF;
        #1;
        chk("spur.rsp",      32'(rsp_valid), 32'h0);
        chk("spur.rsp_res",  rsp_res,        32'h0);
        chk("spur.err_pre",  32'(err_spur),  32'h0);
        @(negedge clk);
        conv_ack = 1'b0; conv_res = 32'h0;
        #1;
        chk("spur.err_spur", 32'(err_spur), 32'h1);
        chk("spur.err_miss", 32'(err_miss), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("clr.in_rst_spur", 32'(err_spur), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("clr.err_spur", 32'(err_spur), 32'h0);
        chk("clr.err_miss", 32'(err_miss), 32'h0);
        chk("clr.busy",     32'(busy),     32'h0);
        chk("clr.frm",      32'(frm),      32'h0);
        issue_step(4'hF, 4'b0001, "post_rst");
        issue_step(4'h0, 4'h0,    "post_flush");

        // Reset mid-operation, then an ack right after reset.
        issue_step(4'b0100, 4'b0100, "mid_iss");
        @(negedge clk);
        rst = 1'b1; req_valid = 4'h0; conv_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0; conv_ack = 1'b1; conv_res = 32'h1234_5678;
        #1;
        chk("mid.rsp",  32'(rsp_valid), 32'h0);
        chk("mid.busy", 32'(busy),      32'h0);
        @(negedge clk);
        conv_ack = 1'b0; conv_res = 32'h0;
        #1;
        chk("mid.err_spur", 32'(err_spur), 32'h1);
        chk("mid.err_miss", 32'(err_miss), 32'h0);
        pend = 1'b0;

        // CONV_LATENCY = 3: back-to-back issues from 0,1,2.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        valid3 = 4'b0111;
        #1;
        chk("l3.t0.ready", 32'(ready3), 32'b0001);
        chk("l3.t0.src",   conv_src3,   src_tab[0]);
        @(negedge clk);
        #1;
        chk("l3.t1.ready", 32'(ready3), 32'b0010);
        chk("l3.t1.rsp",   32'(rsp3),   32'h0);
        chk("l3.t1.busy",  32'(busy3),  32'h1);
        @(negedge clk);
        #1;
        chk("l3.t2.ready", 32'(ready3), 32'b0100);
        chk("l3.t2.src",   conv_src3,   src_tab[2]);
        chk("l3.t2.rsp",   32'(rsp3),   32'h0);
        @(negedge clk);
        valid3 = 4'h0; ack3 = 1'b1; conv_res3 = 32'hA000_0000;
        #1;
        chk("l3.t3.rsp",   32'(rsp3),   32'b0001);
        chk("l3.t3.res",   rsp_res3,    32'hA000_0000);
        chk("l3.t3.ready", 32'(ready3), 32'h0);
        @(negedge clk);
        conv_res3 = 32'hA100_0000;
        #1;
        chk("l3.t4.rsp", 32'(rsp3), 32'b0010);
        chk("l3.t4.res", rsp_res3,  32'hA100_0000);
        @(negedge clk);
        conv_res3 = 32'hA200_0000;
        #1;
        chk("l3.t5.rsp",  32'(rsp3),  32'b0100);
        chk("l3.t5.busy", 32'(busy3), 32'h1);
        @(negedge clk);
        ack3 = 1'b0; conv_res3 = 32'h0;
        #1;
        chk("l3.t6.busy",     32'(busy3),     32'h0);
        chk("l3.t6.rsp",      32'(rsp3),      32'h0);
        chk("l3.t6.err_miss", 32'(err_miss3), 32'h0);
        chk("l3.t6.err_spur", 32'(err_spur3), 32'h0);

        // CONV_LATENCY = 3: reset after two issues drops both results.
        @(negedge clk);
        valid3 = 4'b0011;
        #1;
        chk("l3r.c0.ready", 32'(ready3), 32'b0001);
        @(negedge clk);
        #1;
        chk("l3r.c1.ready", 32'(ready3), 32'b0010);
        @(negedge clk);
        rst = 1'b1; valid3 = 4'h0;
        #1;
        chk("l3r.c2.ready", 32'(ready3), 32'h0);
        @(negedge clk);
        rst = 1'b0; ack3 = 1'b1; conv_res3 = 32'hB000_0000;
        #1;
        chk("l3r.c3.busy", 32'(busy3), 32'h0);
        chk("l3r.c3.rsp",  32'(rsp3),  32'h0);
        @(negedge clk);
        #1;
        chk("l3r.c4.rsp", 32'(rsp3), 32'h0);
        @(negedge clk);
        ack3 = 1'b0; conv_res3 = 32'h0; valid3 = 4'hF;
        #1;
        chk("l3r.c5.ready",    32'(ready3),    32'b0001);
        chk("l3r.c5.err_spur", 32'(err_spur3), 32'h1);
        @(negedge clk);
        valid3 = 4'h0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ecliptic_converter_arbiter.md
Name: ecliptic_converter_arbiter

Overview:
- Shares one single-issue integer-to-float conversion unit among N_REQ requesters using round-robin arbitration.
- The unit's interface: req/src/rm/src_unsigned in; ack/res/inexact returned CONV_LATENCY cycles later.
- Holds the dynamic rounding-mode register and resolves per-request dynamic rounding.
- Tags every issued operation and routes each result back to the requester that issued it.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- CONV_LATENCY, 1, cycles from the edge that samples conv_req to the cycle in which conv_ack is high (1..4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cfg_we  in  1  write strobe for the dynamic rounding mode
- cfg_rm  in  2  new dynamic rounding mode
- frm  out  2  current dynamic rounding mode
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester grant (one-hot or zero)
- req_src  in  32*N_REQ  operand, requester i at bits [32i+31:32i]
- req_rm  in  2*N_REQ  static rounding mode
- req_dyn  in  N_REQ  1 = use frm instead of req_rm
- req_unsigned  in  N_REQ  operand is unsigned
- rsp_valid  out  N_REQ  one-cycle result strobe, one-hot or zero
- rsp_res  out  32  result, shared bus
- rsp_inexact  out  1  inexact flag, shared bus
- conv_req  out  1  issue to conversion unit
- conv_src  out  32  operand to unit
- conv_rm  out  2  resolved rounding mode
- conv_unsigned  out  1  unsigned flag to unit
- conv_ack  in  1  unit result valid
- conv_res  in  32  unit result
- conv_inexact  in  1  unit inexact flag
- busy  out  1  any operation in flight
- err_spurious_ack  out  1  sticky: conv_ack with no op in flight
- err_missing_ack  out  1  sticky: op due but conv_ack low

Behaviour:
- Reset, synchronous and active-high: frm=0 (RNE), round-robin pointer ptr=0, tag pipeline cleared, both error flags 0. During reset all outputs are 0 except frm=0; conv_req=0 and req_ready=0.
- Arbitration is combinational within a cycle. g is the first index i >= ptr with req_valid[i], searching cyclically. req_ready[g]=1 and all other ready bits are 0. With no valid requests, ready is all zero.
- Issue, same cycle as the grant: conv_req=1, conv_src=req_src[g], conv_unsigned=req_unsigned[g], conv_rm = req_dyn[g] ? frm : req_rm[g]. With no grant, conv_req=0 and conv_src/rm/unsigned are 0.
- At a granting edge, ptr <= (g+1) mod N_REQ. ptr is unchanged when there is no grant.
- Throughput: one issue per cycle; no bubbles required.
- Tag pipeline: CONV_LATENCY-deep shift register of {valid, id}. Stage 0 loads {conv_req, g} each edge. The last stage marks the op due in the current cycle.
- Response, combinational: if due.valid and conv_ack, then rsp_valid[due.id]=1, rsp_res=conv_res, rsp_inexact=conv_inexact. Otherwise rsp_valid=0, rsp_res=0, rsp_inexact=0.
- Responses have no backpressure; requesters must take rsp_valid when it strobes.
- conv_ack=1 with due.valid=0: no response; err_spurious_ack set at the edge.
- due.valid=1 with conv_ack=0: the op is dropped; err_missing_ack set at the edge.
- Error flags clear only on rst.
- busy = OR of all tag-pipeline valid bits.
- cfg_we: frm <= cfg_rm at the edge. An issue in the same cycle uses the old frm.
- A requester may hold req_valid across its response. A new request is accepted whenever granted, independent of earlier outstanding ops.
- Reset mid-operation drops in-flight tags. A conv_ack arriving in the cycle after reset deasserts sets err_spurious_ack.

Test Plan:
- N_REQ=4, CONV_LATENCY=1. Requester 2 alone sends src=32'hFFFF_FFFF, req_unsigned=0, req_rm=0 → req_ready=4'b0100, conv_req=1; next cycle rsp_valid=4'b0100, rsp_res=32'hBF80_0000 (-1.0f).
- All four requesters valid continuously for 8 cycles from reset → grants 0,1,2,3,0,1,2,3. rsp_valid follows one cycle later with matching one-hot ids; each requester receives its own result.
- cfg_we=1, cfg_rm=2'd3 in the same cycle requester 0 issues with req_dyn=1 → conv_rm=0 on that issue. The next dyn issue has conv_rm=3; frm reads 3.
- Only requesters 1 and 3 valid, ptr=2 → grant 3, then 1, then 3. Requester 0 raises valid while ptr=0 → grant 0.
- Force conv_ack=1 with busy=0 → err_spurious_ack=1, rsp_valid=0. Suppress ack for an issued op → err_missing_ack=1 and no rsp for it. Assert rst → both flags 0, busy=0.
- CONV_LATENCY=3, back-to-back issues from ids 0,1,2 → rsp_valid on cycles 3,4,5 after the first issue with ids 0,1,2. Reset asserted after 2 issues → no rsp_valid; ptr=0 after reset.
